leaf_merge_arbiter: RTL and testbench

//  Clocked, packet-aware 2:1 round-robin arbiter for the leaf level of the NoC tree.

---
 rtl/leaf_merge_arbiter.sv | 128 ++++++++++++
 tb/tb_leaf_merge_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/leaf_merge_arbiter.sv
// Packet-aware 2:1 round-robin merge for the NoC leaf level, with one registered output slot.
// Optional per-source packet counters are built when LEAF_ARB_PKT_CNT_EN is defined.
module leaf_merge_arbiter #(
    parameter int W       = 9,
    parameter int MAX_PKT = 16
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] In0_data,
    input  logic         In0_valid,
    output logic         In0_ready,
    input  logic [W-1:0] In1_data,
    input  logic         In1_valid,
    output logic         In1_ready,
    output logic [W-1:0] Out_data,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic         Out_src,
`ifdef LEAF_ARB_PKT_CNT_EN
    output logic [15:0]  Pkt_cnt0,
    output logic [15:0]  Pkt_cnt1,
`endif
    output logic         Err_len
);

    localparam int CNT_W = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t             state_q, state_d;
    logic               rr_last;
    logic [CNT_W-1:0]   flit_cnt;
    logic [CNT_W-1:0]   cnt_inc;

    logic [W-1:0]       data_p1;
    logic               vld_p1;
    logic               src_p1;
    logic               err_p1;

    logic               slot_free;
    logic               gnt_any;
    logic               gnt_sel;
    logic               xfer;
    logic               tail;
    logic               force_rel;
    logic [W-1:0]       xfer_data;

    // Stage 0: grant selection and transfer decision
    always_comb begin
        slot_free = !vld_p1 || Out_ready;
        gnt_any   = 1'b1;
        gnt_sel   = 1'b0;
        case (state_q)
            GNT0:    gnt_sel = 1'b0;
            GNT1:    gnt_sel = 1'b1;
            default: begin
                gnt_any = In0_valid || In1_valid;
                gnt_sel = (In0_valid && In1_valid) ? !rr_last : In1_valid;
            end
        endcase

        In0_ready = _RESET && gnt_any && !gnt_sel && slot_free;
        In1_ready = _RESET && gnt_any &&  gnt_sel && slot_free;

        xfer_data = gnt_sel ? In1_data : In0_data;
        xfer      = gnt_sel ? (In1_valid && In1_ready) : (In0_valid && In0_ready);
        tail      = xfer_data[W-1];
        cnt_inc   = flit_cnt + CNT_W'(1);
        force_rel = xfer && !tail && (cnt_inc == CNT_W'(MAX_PKT));

        state_d = state_q;
        if (xfer) begin
            if (tail || force_rel)
                state_d = IDLE;
            else
                state_d = gnt_sel ? GNT1 : GNT0;
        end
    end

    // Stage 1: output register and packet bookkeeping
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            state_q  <= IDLE;
            rr_last  <= 1'b1;
            flit_cnt <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            src_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_p1  <= force_rel;
            if (xfer) begin
                data_p1 <= xfer_data;
                src_p1  <= gnt_sel;
                vld_p1  <= 1'b1;
                if (tail || force_rel) begin
                    rr_last  <= gnt_sel;
                    flit_cnt <= '0;
                end else begin
                    flit_cnt <= cnt_inc;
                end
            end else if (slot_free) begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef LEAF_ARB_PKT_CNT_EN
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            Pkt_cnt0 <= '0;
            Pkt_cnt1 <= '0;
        end else if (xfer && (tail || force_rel)) begin
            if (gnt_sel)
                Pkt_cnt1 <= Pkt_cnt1 + 16'd1;
            else
                Pkt_cnt0 <= Pkt_cnt0 + 16'd1;
        end
    end
`endif

    assign Out_data  = data_p1;
    assign Out_valid = vld_p1;
    assign Out_src   = src_p1;
    assign Err_len   = err_p1;

endmodule

// File: tb/tb_leaf_merge_arbiter.sv
// Randomized bench for leaf_merge_arbiter against a packet-level reference model.
// Builds with or without LEAF_ARB_PKT_CNT_EN.
module tb_leaf_merge_arbiter;

    localparam int W       = 9;
    localparam int MAX_PKT = 16;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic [W-1:0] in0_data, in1_data;
    logic         in0_valid, in1_valid, in0_ready, in1_ready;
    logic [W-1:0] out_data;
    logic         out_valid, out_ready, out_src, err_len;
`ifdef LEAF_ARB_PKT_CNT_EN
    logic [15:0]  pkt_cnt0, pkt_cnt1;
`endif

    always #5 CLK = ~CLK;

    leaf_merge_arbiter #(.W(W), .MAX_PKT(MAX_PKT)) dut (
        .CLK       (CLK),
        ._RESET    (rst_n),
        .In0_data  (in0_data),
        .In0_valid (in0_valid),
        .In0_ready (in0_ready),
        .In1_data  (in1_data),
        .In1_valid (in1_valid),
        .In1_ready (in1_ready),
        .Out_data  (out_data),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .Out_src   (out_src),
`ifdef LEAF_ARB_PKT_CNT_EN
        .Pkt_cnt0  (pkt_cnt0),
        .Pkt_cnt1  (pkt_cnt1),
`endif
        .Err_len   (err_len)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // source flit queues and stimulus knobs
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int vprob = 100;
    int rprob = 100;

    // reference model: packet owner (-1 = none), last winner, flits in current packet
    int           owner   = -1;
    bit           rr_last = 1'b1;
    int           cnt     = 0;
    logic         exp_vld = 1'b0;
    logic         exp_src = 1'b0;
    logic         exp_err = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic [15:0]  pkts[2] = '{16'd0, 16'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic gen_pkt(input int src, input int len);
        logic [W-1:0] f;
        for (int i = 0; i < len; i++) begin
            f = {(i == len - 1), (W-1)'($urandom)};
            if (src == 0) q0.push_back(f);
            else          q1.push_back(f);
        end
    endtask

    task automatic step(input bit rst);
        int           g;
        bit           free, v0, v1, xf;
        logic [W-1:0] f;
        @(negedge CLK);
        chk("out_valid", 32'(out_valid), 32'(exp_vld));
        chk("out_data",  32'(out_data),  32'(exp_data));
        chk("out_src",   32'(out_src),   32'(exp_src));
        chk("err_len",   32'(err_len),   32'(exp_err));
`ifdef LEAF_ARB_PKT_CNT_EN
        chk("pkt_cnt0",  32'(pkt_cnt0),  32'(pkts[0]));
        chk("pkt_cnt1",  32'(pkt_cnt1),  32'(pkts[1]));
`endif
        rst_n     = !rst;
        v0        = (q0.size() > 0) && (rst || int'($urandom_range(99)) < vprob);
        v1        = (q1.size() > 0) && (rst || int'($urandom_range(99)) < vprob);
        in0_valid = v0;
        in1_valid = v1;
        in0_data  = v0 ? q0[0] : W'($urandom);
        in1_data  = v1 ? q1[0] : W'($urandom);
        out_ready = (int'($urandom_range(99)) < rprob);
        #1;
        if (rst) begin
            chk("rst_in0_ready", 32'(in0_ready), 32'd0);
            chk("rst_in1_ready", 32'(in1_ready), 32'd0);
            owner = -1; rr_last = 1'b1; cnt = 0;
            exp_vld = 1'b0; exp_data = '0; exp_src = 1'b0; exp_err = 1'b0;
            pkts[0] = 16'd0; pkts[1] = 16'd0;
            return;
        end
        free = !exp_vld || out_ready;
        if (owner >= 0)    g = owner;
        else if (v0 && v1) g = rr_last ? 0 : 1;
        else if (v0)       g = 0;
        else if (v1)       g = 1;
        else               g = -1;
        chk("in0_ready", 32'(in0_ready), 32'((g == 0) && free));
        chk("in1_ready", 32'(in1_ready), 32'((g == 1) && free));
        xf = free && ((g == 0 && v0) || (g == 1 && v1));
        exp_err = 1'b0;
        if (xf) begin
            f = (g == 0) ? q0.pop_front() : q1.pop_front();
            cnt++;
            exp_vld  = 1'b1;
            exp_data = f;
            exp_src  = g[0];
            if (f[W-1] || cnt == MAX_PKT) begin
                exp_err = !f[W-1];
                owner   = -1;
                rr_last = g[0];
                cnt     = 0;
                pkts[g] = pkts[g] + 16'd1;
            end else begin
                owner = g;
            end
        end else if (free) begin
            exp_vld = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = '0; in1_data = '0; out_ready = 1'b0;

        // reset with both sources holding single-flit packets
        q0.push_back(9'h1AA);
        q1.push_back(9'h1BB);
        @(posedge CLK);
        repeat (3) step(1'b1);
        repeat (3) step(1'b0);
`ifdef LEAF_ARB_PKT_CNT_EN
        chk("sim_tail_cnt0", 32'(pkt_cnt0), 32'd1);
        chk("sim_tail_cnt1", 32'(pkt_cnt1), 32'd1);
`endif

        // single source three-flit packet
        q0.push_back(9'h011);
        q0.push_back(9'h022);
        q0.push_back(9'h133);
        repeat (5) step(1'b0);

        // contention with back-to-back two-flit packets
        for (int i = 0; i < 6; i++) begin
            gen_pkt(0, 2);
            gen_pkt(1, 2);
        end
        repeat (26) step(1'b0);

        // backpressure mid-packet
        gen_pkt(0, 8);
        repeat (3) step(1'b0);
        rprob = 0;
        repeat (4) step(1'b0);
        rprob = 100;
        repeat (8) step(1'b0);

        // length guard: 17 flits without tail on In1, In0 waiting
        for (int i = 0; i < 17; i++) q1.push_back({1'b0, (W-1)'(i)});
        q1.push_back(9'h1FF);
        repeat (2) step(1'b0);
        gen_pkt(0, 3);
        repeat (26) step(1'b0);

        // random traffic with a mid-traffic reset per round
        vprob = 70;
        rprob = 70;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 30; i++) gen_pkt(int'($urandom_range(1)), int'($urandom_range(20, 1)));
            repeat (300) step(1'b0);
            q0.delete();
            q1.delete();
            step(1'b1);
            step(1'b1);
        end
        for (int i = 0; i < 20; i++) gen_pkt(int'($urandom_range(1)), int'($urandom_range(20, 1)));
        vprob = 100;
        rprob = 100;
        repeat (250) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
